// File: rtl/rr_arb4_dec_if.sv
// Request/grant bundle for the four-way round-robin arbiter.
// The master side drives the enable and request vector; the slave side
// (the arbiter) returns the one-hot grant, winner index, valid and the
// hold-timeout pulse.
interface rr_arb4_dec_if;
  logic       i_en;
  logic [3:0] i_req;
  logic [3:0] o_gnt;
  logic [1:0] o_gnt_idx;
  logic       o_gnt_vld;
  logic       o_timeout;

  modport master (
    output i_en,
    output i_req,
    input  o_gnt,
    input  o_gnt_idx,
    input  o_gnt_vld,
    input  o_timeout
  );

  modport slave (
    input  i_en,
    input  i_req,
    output o_gnt,
    output o_gnt_idx,
    output o_gnt_vld,
    output o_timeout
  );
endinterface

// File: rtl/rr_arb4_dec.sv
// Four-requester round-robin arbiter for one shared resource.
// The winner is found by scanning requests starting at a rotating priority
// pointer, then expanded to a one-hot grant with an enable-gated 2-to-4
// decode. A grant lasts until its owner drops the request, the enable
// falls, or the hold counter reaches MAX_HOLD (0 disables the timeout).
// Every release goes through IDLE, so two grants are always separated by
// at least one cycle with no grant and can never overlap.
module rr_arb4_dec #(
  parameter int MAX_HOLD = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  rr_arb4_dec_if.slave bus
);

  // The hold counter only ever needs to reach MAX_HOLD-1; keep at least one bit.
  localparam int CW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] CNT_LAST = (MAX_HOLD == 0) ? '0 : CW'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state_q;
  logic [3:0]    gnt_q;
  logic [1:0]    gntIdx_q;
  logic          timeout_q;
  logic [1:0]    ptr_q;
  logic [CW-1:0] cnt_q;

  logic [2:0]    pick;
  logic          winFound;
  logic [1:0]    winIdx;
  logic          ownerReq;
  logic          holdExpired;

  // Enable-gated 2-to-4 decode, same as the dec2 blocks.
  function automatic logic [3:0] dec2(input logic en, input logic [1:0] idx);
    logic [3:0] y;
    y = 4'b0000;
    if (en) begin
      y[idx] = 1'b1;
    end
    return y;
  endfunction

  // First set request scanning ptr, ptr+1, ... (mod 4); bit 2 flags "found".
  function automatic logic [2:0] rrPick(input logic [3:0] req, input logic [1:0] ptr);
    logic [2:0] found;
    logic [1:0] cand;
    found = 3'b000;
    cand  = 2'b00;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) begin
        found = {1'b1, cand};
      end
    end
    return found;
  endfunction

  assign pick        = rrPick(bus.i_req, ptr_q);
  assign winFound    = pick[2];
  assign winIdx      = pick[1:0];
  assign ownerReq    = bus.i_req[gntIdx_q];
  assign holdExpired = (MAX_HOLD != 0) && (cnt_q == CNT_LAST);

  // Arbitration FSM: grant from IDLE, release back to IDLE in fixed priority
  // (enable low, owner drop, then hold timeout), advancing the pointer past
  // the released owner.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      gnt_q     <= 4'b0000;
      gntIdx_q  <= 2'd0;
      timeout_q <= 1'b0;
      ptr_q     <= 2'd0;
      cnt_q     <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.i_en && winFound) begin
            state_q  <= GRANT;
            gntIdx_q <= winIdx;
            gnt_q    <= dec2(1'b1, winIdx);
            cnt_q    <= '0;
          end
        end
        GRANT: begin
          if (!bus.i_en || !ownerReq || holdExpired) begin
            state_q   <= IDLE;
            gnt_q     <= 4'b0000;
            ptr_q     <= gntIdx_q + 2'd1;
            cnt_q     <= '0;
            timeout_q <= bus.i_en && ownerReq && holdExpired;
          end else if (MAX_HOLD != 0) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= 4'b0000;
        end
      endcase
    end
  end

  assign bus.o_gnt     = gnt_q;
  assign bus.o_gnt_idx = gntIdx_q;
  assign bus.o_gnt_vld = |gnt_q;
  assign bus.o_timeout = timeout_q;

endmodule

// File: tb/tb_rr_arb4_dec.sv
// Scoreboard bench for rr_arb4_dec. Two instances share clock, reset and
// inputs: dutA with MAX_HOLD=4 and dutB with MAX_HOLD=0 (no timeout).
// Directed vectors push hand-computed expected outputs into a queue; a
// monitor pops one entry per clock and compares it with the selected DUT.
module tb_rr_arb4_dec;

  typedef struct {
    string      tag;
    logic       sel;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       to;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] req;

  int numChecks;
  int numFails;
  exp_t expQ[$];

  rr_arb4_dec_if busA ();
  rr_arb4_dec_if busB ();

  assign busA.i_en  = en;
  assign busA.i_req = req;
  assign busB.i_en  = en;
  assign busB.i_req = req;

  rr_arb4_dec #(.MAX_HOLD(4)) dutA (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (busA)
  );

  rr_arb4_dec #(.MAX_HOLD(0)) dutB (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (busB)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one DUT's outputs with an expected grant/index/timeout.
  task automatic checkOutput(input string tag, input logic sel,
                             input logic [3:0] eg, input logic [1:0] ei, input logic et);
    logic [3:0] ag;
    logic [1:0] ai;
    logic       av;
    logic       at;
    if (sel) begin
      ag = busB.o_gnt; ai = busB.o_gnt_idx; av = busB.o_gnt_vld; at = busB.o_timeout;
    end else begin
      ag = busA.o_gnt; ai = busA.o_gnt_idx; av = busA.o_gnt_vld; at = busA.o_timeout;
    end
    numChecks++;
    if (ag !== eg || ai !== ei || av !== (|eg) || at !== et) begin
      numFails++;
      $display("[TB] FAIL %s (dut%s): got gnt=%b idx=%0d vld=%b to=%b, expected gnt=%b idx=%0d vld=%b to=%b",
               tag, sel ? "B" : "A", ag, ai, av, at, eg, ei, |eg, et);
    end
  endtask

  // Structural invariants: one-hot-or-zero grant and valid tracking the grant.
  task automatic checkInvariants(input string name, input logic [3:0] g, input logic v);
    numChecks++;
    if (!$onehot0(g)) begin
      numFails++;
      $display("[TB] FAIL %s_onehot: got gnt=%b, expected at most one bit set", name, g);
    end
    numChecks++;
    if (v !== (|g)) begin
      numFails++;
      $display("[TB] FAIL %s_vld: got vld=%b, expected %b for gnt=%b", name, v, |g, g);
    end
  endtask

  // Monitor: 2 time units after each rising edge, check invariants and pop one expectation.
  always @(posedge clk) begin
    exp_t e;
    #2;
    checkInvariants("dutA", busA.o_gnt, busA.o_gnt_vld);
    checkInvariants("dutB", busB.o_gnt, busB.o_gnt_vld);
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput(e.tag, e.sel, e.gnt, e.idx, e.to);
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic applyStimulus(input string tag, input logic sel, input logic e,
                               input logic [3:0] r, input logic [3:0] eg,
                               input logic [1:0] ei, input logic et);
    exp_t x;
    en    = e;
    req   = r;
    x.tag = tag;
    x.sel = sel;
    x.gnt = eg;
    x.idx = ei;
    x.to  = et;
    expQ.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // Reset pulse placed between edges, after the monitor has sampled.
  task automatic resetPulse();
    #3;
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int order[5];
    numChecks = 0;
    numFails  = 0;
    rst = 1'b1;
    en  = 1'b0;
    req = 4'b0000;

    // Reset state of both instances.
    #12;
    checkOutput("reset_state", 1'b0, 4'b0000, 2'd0, 1'b0);
    checkOutput("reset_state", 1'b1, 4'b0000, 2'd0, 1'b0);
    rst = 1'b0;

    // Single requester held three cycles, then dropped.
    applyStimulus("t1_grant0_c1", 1'b0, 1'b1, 4'b0001, 4'b0001, 2'd0, 1'b0);
    applyStimulus("t1_grant0_c2", 1'b0, 1'b1, 4'b0001, 4'b0001, 2'd0, 1'b0);
    applyStimulus("t1_grant0_c3", 1'b0, 1'b1, 4'b0001, 4'b0001, 2'd0, 1'b0);
    applyStimulus("t1_release",   1'b0, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);
    applyStimulus("t1_idle",      1'b0, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);

    // All four requesting with MAX_HOLD=4: rotation 0,1,2,3,0 with timeouts.
    resetPulse();
    order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) begin
      for (int c = 0; c < 4; c++) begin
        applyStimulus("t2_hold", 1'b0, 1'b1, 4'b1111, 4'b0001 << order[i], 2'(order[i]), 1'b0);
      end
      applyStimulus("t2_timeout", 1'b0, 1'b1, 4'b1111, 4'b0000, 2'(order[i]), 1'b1);
    end

    // Pointer rotation: grant 1, then 1010 picks 3 first, then 1.
    applyStimulus("t3_grant1",     1'b0, 1'b1, 4'b0010, 4'b0010, 2'd1, 1'b0);
    applyStimulus("t3_ignore3",    1'b0, 1'b1, 4'b1010, 4'b0010, 2'd1, 1'b0);
    applyStimulus("t3_release1",   1'b0, 1'b1, 4'b1000, 4'b0000, 2'd1, 1'b0);
    applyStimulus("t3_grant3",     1'b0, 1'b1, 4'b1010, 4'b1000, 2'd3, 1'b0);
    applyStimulus("t3_release3",   1'b0, 1'b1, 4'b0010, 4'b0000, 2'd3, 1'b0);
    applyStimulus("t3_grant1b",    1'b0, 1'b1, 4'b1010, 4'b0010, 2'd1, 1'b0);
    applyStimulus("t3_release1b",  1'b0, 1'b1, 4'b0000, 4'b0000, 2'd1, 1'b0);

    // Enable drop during a grant to 2, then no grants while disabled.
    applyStimulus("t4_grant2",     1'b0, 1'b1, 4'b0100, 4'b0100, 2'd2, 1'b0);
    applyStimulus("t4_hold2",      1'b0, 1'b1, 4'b1111, 4'b0100, 2'd2, 1'b0);
    applyStimulus("t4_en_drop",    1'b0, 1'b0, 4'b1111, 4'b0000, 2'd2, 1'b0);
    applyStimulus("t4_disabled",   1'b0, 1'b0, 4'b1111, 4'b0000, 2'd2, 1'b0);
    applyStimulus("t4_disabled",   1'b0, 1'b0, 4'b1111, 4'b0000, 2'd2, 1'b0);
    applyStimulus("t4_ptr3_grant", 1'b0, 1'b1, 4'b1111, 4'b1000, 2'd3, 1'b0);
    applyStimulus("t5_hold3",      1'b0, 1'b1, 4'b1111, 4'b1000, 2'd3, 1'b0);

    // Asynchronous reset mid-grant to 3: grant must clear before the next edge.
    #3;
    rst = 1'b1;
    #1;
    checkOutput("t5_async_rst", 1'b0, 4'b0000, 2'd0, 1'b0);
    #1;
    rst = 1'b0;
    applyStimulus("t5_after_rst",  1'b0, 1'b1, 4'b1111, 4'b0001, 2'd0, 1'b0);
    applyStimulus("t5_release",    1'b0, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);

    // MAX_HOLD=0 instance: continuous grant to 2 for 20 cycles, no timeout.
    for (int c = 0; c < 20; c++) begin
      applyStimulus("t6_no_timeout", 1'b1, 1'b1, 4'b0100, 4'b0100, 2'd2, 1'b0);
    end
    applyStimulus("t6_release",    1'b1, 1'b1, 4'b0000, 4'b0000, 2'd2, 1'b0);

    // Let the monitor drain the last expectation.
    #5;
    numChecks++;
    if (expQ.size() != 0) begin
      numFails++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending entries, expected 0", expQ.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
